// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: feeds the configuration-chain head of a tile group.
// Configuration words arrive on a valid/ready stream and are shifted MSB-first
// onto ccff_head. prog_clk_en gates the tile's prog_clk so that the chain
// shifts exactly CHAIN_LEN times per load. The bits displaced from ccff_tail
// are returned as a readback stream.
//
// Ports:
//   prog_clk, prog_reset_n   configuration clock, async active-low reset
//   start, abort             begin a load (IDLE only) / cancel a load in progress
//   cfg_data/valid/ready     configuration word stream (transfer = valid & ready)
//   ccff_head, ccff_tail     serial chain head output / chain tail input
//   prog_clk_en              chain shifts on the next prog_clk edge when 1
//   readback_bit/valid       old chain bit leaving the tail in a shift cycle
//   busy, done, aborted      LOAD state flag, completion pulse, abort pulse
module ccff_bitstream_loader #(
  parameter int unsigned CHAIN_LEN = 20,
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              prog_clk_en,
  output logic              readback_bit,
  output logic              readback_valid,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam int unsigned NUM_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  // Bits of the final word that actually enter the chain.
  localparam int unsigned LAST_BITS = ((CHAIN_LEN % WORD_W) == 0) ? WORD_W
                                                                  : (CHAIN_LEN % WORD_W);
  localparam int unsigned REM_W     = $clog2(WORD_W + 1);
  localparam int unsigned WCNT_W    = $clog2(NUM_WORDS + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   buf_q, buf_d;
  logic [REM_W-1:0]    rem_q, rem_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WCNT_W-1:0]   words_q, words_d;
  logic                aborted_q, aborted_d;

  logic                shift_c;
  logic                last_shift_c;
  logic                ready_c;
  logic                xfer_c;

  // Datapath decode from registered state only.
  always_comb begin
    shift_c      = (state_q == ST_LOAD) && (rem_q != '0);
    last_shift_c = shift_c && (bit_cnt_q == CNT_W'(CHAIN_LEN - 1));
    // rem_q == 1 in LOAD implies the last buffered bit is shifting now,
    // so the next word can be taken without a bubble.
    ready_c      = (state_q == ST_LOAD) && (rem_q <= REM_W'(1)) &&
                   (words_q < WCNT_W'(NUM_WORDS));
    xfer_c       = cfg_valid && ready_c && !abort;
  end

  // Next-state logic for the control FSM and word buffer.
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    rem_d     = rem_q;
    bit_cnt_d = bit_cnt_q;
    words_d   = words_q;
    aborted_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d   = ST_LOAD;
          buf_d     = '0;
          rem_d     = '0;
          bit_cnt_d = '0;
          words_d   = '0;
        end
      end

      ST_LOAD: begin
        if (abort) begin
          // Flush; a word offered in this cycle is dropped.
          state_d   = ST_IDLE;
          buf_d     = '0;
          rem_d     = '0;
          aborted_d = 1'b1;
        end else begin
          if (shift_c) begin
            buf_d     = buf_q << 1;
            rem_d     = rem_q - REM_W'(1);
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
          // A new word overrides the shifted-out last bit of the previous one.
          if (xfer_c) begin
            buf_d   = cfg_data;
            rem_d   = (words_q == WCNT_W'(NUM_WORDS - 1)) ? REM_W'(LAST_BITS)
                                                          : REM_W'(WORD_W);
            words_d = words_q + WCNT_W'(1);
          end
          // Leftover LSBs of the final word are discarded here.
          if (last_shift_c) begin
            state_d = ST_DONE;
            buf_d   = '0;
            rem_d   = '0;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q   <= ST_IDLE;
      buf_q     <= '0;
      rem_q     <= '0;
      bit_cnt_q <= '0;
      words_q   <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      rem_q     <= rem_d;
      bit_cnt_q <= bit_cnt_d;
      words_q   <= words_d;
      aborted_q <= aborted_d;
    end
  end

  // Output decode; readback_bit is the only path from an input (ccff_tail).
  always_comb begin
    cfg_ready      = ready_c;
    ccff_head      = shift_c && buf_q[WORD_W-1];
    prog_clk_en    = shift_c;
    readback_valid = shift_c;
    readback_bit   = shift_c && ccff_tail;
    busy           = (state_q == ST_LOAD);
    done           = (state_q == ST_DONE);
    aborted        = aborted_q;
  end

endmodule
